fmrv32im_div_arb: RTL and testbench
===================================

FMRV32IM_DIV_ARB -- requirements
Module: fmrv32im_div_arb

Interface
REQ-001 SHALL have parameters:
- TIMEOUT, 63: maximum BUSY cycles before an error response.
- BYPASS_ZERO, 1: 1 enables the divide-by-zero fast path.
REQ-002 SHALL have ports (clock and reset first):
- CLK  in  1  single clock; all flops on rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- REQA_VALID / REQB_VALID  in  1  requester A/B has an operation pending.
- REQA_OP / REQB_OP  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- REQA_RS1, REQA_RS2 / REQB_RS1, REQB_RS2  in  32  operands.
- REQA_READY / REQB_READY  out  1  accept strobe; combinational.
- RSPA_VALID / RSPB_VALID  out  1  one-cycle result strobe.
- RSPA_ERR / RSPB_ERR  out  1  timeout flag, qualified by RSPx_VALID.
- RSP_RD  out  32  result, shared by both requesters, qualified by RSPx_VALID.
- DIV_INST_DIV, DIV_INST_DIVU, DIV_INST_REM, DIV_INST_REMU  out  1  divider start, one-hot, one-cycle pulse.
- DIV_RS1, DIV_RS2  out  32  divider operands.
- DIV_WAIT  in  1  divider executing.
- DIV_READY  in  1  divider result valid this cycle.
- DIV_RD  in  32  divider result.

Function
REQ-003 SHALL implement states IDLE, ISSUE, BUSY and RESP.
REQ-004 IDLE with any REQx_VALID SHALL grant exactly one requester:
- Raise its REQx_READY for that cycle.
- Latch its OP, RS1, RS2 and ID at the clock edge.
- Toggle the round-robin pointer to the other requester.
REQ-005 Arbitration SHALL be:
- Single requester valid: that requester wins regardless of the pointer.
- Both valid: the requester named by the pointer wins.
- Pointer reset value: A.
REQ-006 REQA_READY and REQB_READY SHALL be 0 in every state other than IDLE, and never both 1.
REQ-007 Zero-divisor fast path (BYPASS_ZERO=1 and latched RS2==0):
- IDLE goes directly to RESP; the divider is not started.
- RSP_RD = 32'hFFFF_FFFF for DIV/DIVU.
- RSP_RD = RS1 for REM/REMU.
REQ-008 Normal path SHALL be IDLE -> ISSUE.
REQ-009 ISSUE SHALL:
- Last exactly one cycle.
- Drive DIV_RS1/DIV_RS2 from the latched operands.
- Assert the single DIV_INST_* matching the latched OP.
- Then go to BUSY.
REQ-010 DIV_INST_* SHALL be 0 in every state except ISSUE.
REQ-011 DIV_RS1 and DIV_RS2 SHALL hold the latched operands from ISSUE until leaving BUSY.
REQ-012 BUSY SHALL count cycles from 0:
- DIV_READY=1: capture DIV_RD into the result register, go to RESP.
- Count reaches TIMEOUT without DIV_READY: result = 0, error = 1, go to RESP.
REQ-013 A DIV_READY coinciding with the TIMEOUT cycle SHALL count as success (ERR=0).
REQ-014 DIV_READY seen in any state other than BUSY SHALL be ignored.
REQ-015 RESP SHALL last one cycle:
- Assert RSPx_VALID for the latched ID only.
- Drive RSP_RD from the result register and RSPx_ERR from the error bit.
- Return to IDLE.
REQ-016 RSP_RD SHALL hold its last value outside RESP.
REQ-017 The earliest next grant SHALL be the cycle after RESP (back-to-back throughput: one operation per pass through IDLE).
REQ-018 Normal-path latency with a divider of 33 EXEC cycles SHALL be:
- Grant in cycle T.
- DIV_INST pulse in T+1.
- DIV_READY in T+35.
- RSPx_VALID in T+36.
REQ-019 Fast-path latency SHALL be: grant in T, RSPx_VALID in T+1.
REQ-020 The block SHALL perform no sign handling; it passes operands and results unchanged.
REQ-021 The watchdog counter SHALL be wide enough for TIMEOUT and SHALL clear on entry to BUSY.

Reset
REQ-022 RST_N low SHALL immediately, asynchronously, set:
- State IDLE, pointer A, counter 0.
- Latched operands, ID, result and error = 0.
- All outputs 0, including REQx_READY, RSPx_VALID, RSPx_ERR, RSP_RD, DIV_INST_* and DIV_RS*.
REQ-023 Reset during ISSUE, BUSY or RESP SHALL abort with no response, and the pending response SHALL never appear after reset release.
REQ-024 Requests SHALL be grantable in the first cycle after RST_N deassertion.

Verification
REQ-025 Single A: DIVU 100/7 granted in T -> DIV_INST_DIVU pulse in T+1 only; RSPA_VALID in T+36; RSP_RD = 14; ERR = 0; RSPB_VALID never asserted.
REQ-026 Contention: A DIV 0xFFFFFFF9/2 and B REM 7/-2 held valid from reset release ->
- A granted first: RSPA RD = 0xFFFFFFFD.
- Then B granted: RSPB RD = 1.
- Then A again if still valid.
REQ-027 Zero divisor with bypass: B DIV 5/0 -> RSPB_VALID in T+1, RD = 0xFFFFFFFF; REM 5/0 -> RD = 5; no DIV_INST_* pulse.
REQ-028 Timeout: divider model never raises DIV_READY -> RSPx_VALID with ERR = 1 and RD = 0 exactly TIMEOUT+1 cycles after ISSUE; a late DIV_READY afterwards is ignored.
REQ-029 Reset mid-BUSY: pull RST_N low 10 cycles after ISSUE -> all outputs 0 within the same cycle; no RSPx_VALID after release; a new request is granted on the first cycle after release.
REQ-030 Signed overflow: A DIV 0x80000000 / 0xFFFFFFFF -> RD = 0x80000000; A REM with the same operands -> RD = 0.

Source files
------------

// File: rtl/fmrv32im_div_arb.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// fmrv32im_div_arb
//
// Shares one multi-cycle divider between two requesters (A and B). One
// operation is in flight at a time. The arbiter grants a requester in IDLE,
// starts the divider with a one-cycle DIV_INST_* pulse, waits for the result
// under a watchdog, and returns the result to the requester that was granted.
// A zero divisor is answered directly, without starting the divider, when
// BYPASS_ZERO is set.
//
// Handshake: a request is accepted in a cycle where REQx_VALID and REQx_READY
// are both 1 at the rising clock edge. READY is combinational and is only
// raised in IDLE, for at most one requester. The requester must hold OP/RS1/RS2
// stable while VALID is high. The response is a single-cycle RSPx_VALID strobe
// with no back-pressure; RSP_RD and RSPx_ERR are meaningful only with it.
//
// Parameters
//   TIMEOUT      maximum BUSY cycles before an error response (>= 1)
//   BYPASS_ZERO  1 answers a zero divisor directly without the divider
//
// Ports
//   CLK, RST_N                 clock (rising edge), async active-low reset
//   REQx_VALID/OP/RS1/RS2      requester A/B operation request
//   REQx_READY                 accept strobe (combinational)
//   RSPx_VALID, RSPx_ERR       per-requester result strobe and timeout flag
//   RSP_RD                     shared result, holds between responses
//   DIV_INST_*                 one-hot divider start pulse
//   DIV_RS1, DIV_RS2           divider operands
//   DIV_WAIT, DIV_READY, DIV_RD  divider status and result
//   DBG_STATE                  current FSM state (IDLE=0 ISSUE=1 BUSY=2 RESP=3)
//   DBG_DIV_WAIT               divider reports executing while we are in BUSY
// ---------------------------------------------------------------------------
module fmrv32im_div_arb #(
   parameter int unsigned TIMEOUT     = 63,
   parameter logic        BYPASS_ZERO = 1'b1
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        REQA_VALID,
   input  logic [1:0]  REQA_OP,
   input  logic [31:0] REQA_RS1,
   input  logic [31:0] REQA_RS2,
   output logic        REQA_READY,
   input  logic        REQB_VALID,
   input  logic [1:0]  REQB_OP,
   input  logic [31:0] REQB_RS1,
   input  logic [31:0] REQB_RS2,
   output logic        REQB_READY,
   output logic        RSPA_VALID,
   output logic        RSPA_ERR,
   output logic        RSPB_VALID,
   output logic        RSPB_ERR,
   output logic [31:0] RSP_RD,
   output logic        DIV_INST_DIV,
   output logic        DIV_INST_DIVU,
   output logic        DIV_INST_REM,
   output logic        DIV_INST_REMU,
   output logic [31:0] DIV_RS1,
   output logic [31:0] DIV_RS2,
   input  logic        DIV_WAIT,
   input  logic        DIV_READY,
   input  logic [31:0] DIV_RD,
   output logic [1:0]  DBG_STATE,
   output logic        DBG_DIV_WAIT
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_BUSY  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic              ptr_q, ptr_d;      // 0: A has priority, 1: B
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        op_q, op_d;
   logic [31:0]       rs1_q, rs1_d;
   logic [31:0]       rs2_q, rs2_d;
   logic              id_q, id_d;        // 0: A, 1: B
   logic [31:0]       res_q, res_d;
   logic              err_q, err_d;

   logic              pick_b;
   logic              grant_a, grant_b;
   logic [1:0]        sel_op;
   logic [31:0]       sel_rs1, sel_rs2;
   logic              in_issue, in_resp;

   // B wins when it is the only one asking, or both ask and the pointer names B.
   assign pick_b  = REQB_VALID && (!REQA_VALID || ptr_q);
   assign sel_op  = pick_b ? REQB_OP  : REQA_OP;
   assign sel_rs1 = pick_b ? REQB_RS1 : REQA_RS1;
   assign sel_rs2 = pick_b ? REQB_RS2 : REQA_RS2;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      id_d    = id_q;
      res_d   = res_q;
      err_d   = err_q;
      grant_a = 1'b0;
      grant_b = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (REQA_VALID || REQB_VALID) begin
               grant_a = !pick_b;
               grant_b = pick_b;
               op_d    = sel_op;
               rs1_d   = sel_rs1;
               rs2_d   = sel_rs2;
               id_d    = pick_b;
               ptr_d   = !pick_b;
               if (BYPASS_ZERO && (sel_rs2 == 32'd0)) begin
                  // DIV/DIVU by zero give all ones, REM/REMU give the dividend.
                  res_d   = sel_op[1] ? sel_rs1 : 32'hFFFF_FFFF;
                  err_d   = 1'b0;
                  state_d = S_RESP;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end

         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_BUSY;
         end

         S_BUSY: begin
            // A result on the last allowed cycle still wins over the watchdog.
            if (DIV_READY) begin
               res_d   = DIV_RD;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               // This is the TIMEOUT-th BUSY cycle: give up.
               res_d   = 32'd0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_RESP: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         ptr_q   <= 1'b0;
         cnt_q   <= '0;
         op_q    <= 2'b00;
         rs1_q   <= 32'd0;
         rs2_q   <= 32'd0;
         id_q    <= 1'b0;
         res_q   <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         id_q    <= id_d;
         res_q   <= res_d;
         err_q   <= err_d;
      end
   end

   // The state register sits at IDLE throughout reset, so the accept strobe
   // is additionally gated by RST_N to keep it low while reset is held.
   assign REQA_READY = grant_a && RST_N;
   assign REQB_READY = grant_b && RST_N;

   assign in_issue = (state_q == S_ISSUE);
   assign in_resp  = (state_q == S_RESP);

   assign DIV_INST_DIV  = in_issue && (op_q == 2'b00);
   assign DIV_INST_DIVU = in_issue && (op_q == 2'b01);
   assign DIV_INST_REM  = in_issue && (op_q == 2'b10);
   assign DIV_INST_REMU = in_issue && (op_q == 2'b11);

   // The operand registers only change on a grant, so they are stable from
   // ISSUE through BUSY.
   assign DIV_RS1 = rs1_q;
   assign DIV_RS2 = rs2_q;

   assign RSPA_VALID = in_resp && !id_q;
   assign RSPB_VALID = in_resp &&  id_q;
   assign RSPA_ERR   = in_resp && !id_q && err_q;
   assign RSPB_ERR   = in_resp &&  id_q && err_q;
   // The result register only loads on the edge into RESP, so it holds the
   // last response value at all other times.
   assign RSP_RD     = res_q;

   assign DBG_STATE    = state_q;
   assign DBG_DIV_WAIT = DIV_WAIT && (state_q == S_BUSY);

endmodule

// File: tb/tb_fmrv32im_div_arb.sv
`timescale 1ns/1ps
module tb_fmrv32im_div_arb;

   localparam int TMO = 63;
   localparam int EW  = 66;   // {due[31:0], id, err, rd[31:0]}

   // ---------------- clock / reset ----------------
   logic CLK = 1'b0;
   logic RST_N;
   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc++;

   // ---------------- DUT signals ----------------
   logic        REQA_VALID, REQB_VALID;
   logic [1:0]  REQA_OP, REQB_OP;
   logic [31:0] REQA_RS1, REQA_RS2, REQB_RS1, REQB_RS2;
   logic        REQA_READY, REQB_READY;
   logic        RSPA_VALID, RSPA_ERR, RSPB_VALID, RSPB_ERR;
   logic [31:0] RSP_RD;
   logic        DIV_INST_DIV, DIV_INST_DIVU, DIV_INST_REM, DIV_INST_REMU;
   logic [31:0] DIV_RS1, DIV_RS2;
   logic        DIV_WAIT, DIV_READY;
   logic [31:0] DIV_RD;
   logic [1:0]  DBG_STATE;
   logic        DBG_DIV_WAIT;

   fmrv32im_div_arb #(.TIMEOUT(TMO), .BYPASS_ZERO(1'b1)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .REQA_VALID(REQA_VALID), .REQA_OP(REQA_OP), .REQA_RS1(REQA_RS1),
      .REQA_RS2(REQA_RS2), .REQA_READY(REQA_READY),
      .REQB_VALID(REQB_VALID), .REQB_OP(REQB_OP), .REQB_RS1(REQB_RS1),
      .REQB_RS2(REQB_RS2), .REQB_READY(REQB_READY),
      .RSPA_VALID(RSPA_VALID), .RSPA_ERR(RSPA_ERR),
      .RSPB_VALID(RSPB_VALID), .RSPB_ERR(RSPB_ERR), .RSP_RD(RSP_RD),
      .DIV_INST_DIV(DIV_INST_DIV), .DIV_INST_DIVU(DIV_INST_DIVU),
      .DIV_INST_REM(DIV_INST_REM), .DIV_INST_REMU(DIV_INST_REMU),
      .DIV_RS1(DIV_RS1), .DIV_RS2(DIV_RS2),
      .DIV_WAIT(DIV_WAIT), .DIV_READY(DIV_READY), .DIV_RD(DIV_RD),
      .DBG_STATE(DBG_STATE), .DBG_DIV_WAIT(DBG_DIV_WAIT)
   );

   // ---------------- checking ----------------
   int n_total = 0;
   int n_bad   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   // RISC-V M-extension division rules.
   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      sa = a;
      sb = b;
      case (op)
         2'd0: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return 32'(sa / sb);
         end
         2'd1: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         2'd2: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(sa % sb);
         end
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   // ---------------- divider model ----------------
   // Started by any DIV_INST_* pulse; result appears div_lat cycles later.
   int          div_lat   = 34;
   logic        div_never = 1'b0;
   logic        late_rdy  = 1'b0;
   logic        div_pend  = 1'b0;
   int          div_due   = 0;
   logic [31:0] div_res   = 32'd0;
   logic        m_rdy = 1'b0, m_wait = 1'b0;
   logic [31:0] m_rd  = 32'd0;
   logic [1:0]  div_op;

   assign DIV_READY = m_rdy;
   assign DIV_WAIT  = m_wait;
   assign DIV_RD    = m_rd;

   always @(negedge CLK) begin
      if (!RST_N) begin
         div_pend = 1'b0;
         m_rdy    = 1'b0;
         m_rd     = 32'd0;
      end else begin
         m_rdy = 1'b0;
         m_rd  = $urandom;   // garbage whenever no result is presented
         if (div_pend && cyc == div_due) begin
            div_pend = 1'b0;
            if (!div_never) begin
               m_rdy = 1'b1;
               m_rd  = div_res;
            end
         end
         if (late_rdy) m_rdy = 1'b1;
         if (DIV_INST_DIV || DIV_INST_DIVU || DIV_INST_REM || DIV_INST_REMU) begin
            div_op   = DIV_INST_DIVU ? 2'd1 : DIV_INST_REM ? 2'd2 : DIV_INST_REMU ? 2'd3 : 2'd0;
            div_pend = 1'b1;
            div_due  = cyc + div_lat;
            div_res  = ref_div(div_op, DIV_RS1, DIV_RS2);
         end
      end
      m_wait = div_pend;
   end

   // ---------------- scoreboard / monitor ----------------
   logic [EW-1:0] exp_q[$];
   logic [33:0]   rsp_log[$];   // {id, err, rd}
   int            rsp_cnt  = 0;
   logic          rr_b     = 1'b0;   // model: B has priority on contention
   int            inst_cyc = -1;
   int            rs_until = 0;
   logic [3:0]    inst_vec = 4'd0;
   logic [31:0]   inst_rs1 = 32'd0, inst_rs2 = 32'd0;

   logic          m_resp, m_busy, m_win_b, m_err;
   logic [1:0]    m_op;
   logic [31:0]   m_rs1, m_rs2, m_res;
   int            m_due;
   logic [EW-1:0] m_e;

   always @(negedge CLK) begin
      if (RST_N) begin
         m_resp = 1'b0;
         if (RSPA_VALID || RSPB_VALID) begin
            m_resp = 1'b1;
            rsp_cnt++;
            rsp_log.push_back({RSPB_VALID, RSPA_ERR | RSPB_ERR, RSP_RD});
            check_eq("rsp_both", 64'(RSPA_VALID && RSPB_VALID), 64'd0);
            if (exp_q.size() == 0) begin
               check_eq("rsp_unexp", 64'd1, 64'd0);
            end else begin
               m_e = exp_q.pop_front();
               check_eq("rsp_cyc", 64'(cyc), 64'(m_e[65:34]));
               check_eq("rsp_id", 64'(RSPB_VALID), 64'(m_e[33]));
               check_eq("rsp_err", 64'({RSPA_ERR, RSPB_ERR}),
                        64'(m_e[33] ? {1'b0, m_e[32]} : {m_e[32], 1'b0}));
               check_eq("rsp_rd", 64'(RSP_RD), 64'(m_e[31:0]));
            end
         end else if (exp_q.size() != 0) begin
            m_e = exp_q[0];
            if (cyc >= int'(m_e[65:34])) begin
               check_eq("rsp_missing", 64'd0, 64'd1);
               void'(exp_q.pop_front());
            end
         end

         check_eq("rdy_both", 64'(REQA_READY && REQB_READY), 64'd0);
         m_busy = m_resp || (exp_q.size() != 0);
         if (m_busy) begin
            check_eq("rdy_busy", 64'({REQA_READY, REQB_READY}), 64'd0);
         end else if (REQA_VALID || REQB_VALID) begin
            m_win_b = (REQA_VALID && REQB_VALID) ? rr_b : REQB_VALID;
            check_eq("grant", 64'({REQA_READY, REQB_READY}), m_win_b ? 64'd1 : 64'd2);
            rr_b  = !m_win_b;
            m_op  = m_win_b ? REQB_OP  : REQA_OP;
            m_rs1 = m_win_b ? REQB_RS1 : REQA_RS1;
            m_rs2 = m_win_b ? REQB_RS2 : REQA_RS2;
            if (m_rs2 == 32'd0) begin
               m_res = m_op[1] ? m_rs1 : 32'hFFFF_FFFF;
               m_err = 1'b0;
               m_due = cyc + 1;
            end else begin
               if (!div_never && div_lat <= TMO) begin
                  m_res = ref_div(m_op, m_rs1, m_rs2);
                  m_err = 1'b0;
                  m_due = cyc + 2 + div_lat;
               end else begin
                  m_res = 32'd0;
                  m_err = 1'b1;
                  m_due = cyc + TMO + 2;
               end
               inst_cyc = cyc + 1;
               inst_vec = 4'b1000 >> m_op;
               inst_rs1 = m_rs1;
               inst_rs2 = m_rs2;
               rs_until = m_due;
            end
            exp_q.push_back({32'(m_due), m_win_b, m_err, m_res});
         end else begin
            check_eq("rdy_idle", 64'({REQA_READY, REQB_READY}), 64'd0);
         end

         check_eq("div_inst", 64'({DIV_INST_DIV, DIV_INST_DIVU, DIV_INST_REM, DIV_INST_REMU}),
                  (cyc == inst_cyc) ? 64'(inst_vec) : 64'd0);
         if (cyc >= inst_cyc && cyc < rs_until)
            check_eq("div_rs", {DIV_RS1, DIV_RS2}, {inst_rs1, inst_rs2});
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_req(input logic id, input logic [1:0] op, input logic [31:0] rs1, input logic [31:0] rs2);
      int   n = 0;
      logic got = 1'b0;
      if (!id) begin
         REQA_VALID = 1'b1; REQA_OP = op; REQA_RS1 = rs1; REQA_RS2 = rs2;
      end else begin
         REQB_VALID = 1'b1; REQB_OP = op; REQB_RS1 = rs1; REQB_RS2 = rs2;
      end
      while (!got && n < 400) begin
         @(negedge CLK);
         got = id ? REQB_READY : REQA_READY;
         n++;
      end
      if (!got) check_eq("grant_tmo", 64'd0, 64'd1);
      @(posedge CLK);
      #1;
      if (!id) REQA_VALID = 1'b0;
      else     REQB_VALID = 1'b0;
   endtask

   task automatic wait_rsps(input int target);
      int n = 0;
      while (rsp_cnt < target && n < 3000) begin
         @(posedge CLK);
         n++;
      end
      #1;
      if (rsp_cnt < target) check_eq("rsp_wait_tmo", 64'(rsp_cnt), 64'(target));
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_ctl"}, 64'({REQA_READY, REQB_READY, RSPA_VALID, RSPB_VALID, RSPA_ERR, RSPB_ERR,
                                   DIV_INST_DIV, DIV_INST_DIVU, DIV_INST_REM, DIV_INST_REMU}), 64'd0);
      check_eq({tag, "_rd"}, 64'(RSP_RD), 64'd0);
      check_eq({tag, "_rs"}, {DIV_RS1, DIV_RS2}, 64'd0);
   endtask

   task automatic rand_requester(input logic id, input int count);
      logic [1:0]  op;
      logic [31:0] rs1, rs2;
      int          gap;
      for (int i = 0; i < count; i++) begin
         op  = 2'($urandom_range(0, 3));
         rs1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 100)) : $urandom;
         case ($urandom_range(0, 5))
            0:       rs2 = 32'd0;
            1:       rs2 = 32'hFFFF_FFFF;
            2:       rs2 = 32'($urandom_range(1, 9));
            default: rs2 = $urandom;
         endcase
         drive_req(id, op, rs1, rs2);
         gap = $urandom_range(0, 3);
         if (gap != 0) begin
            repeat (gap) @(posedge CLK);
            #1;
         end
      end
   endtask

   // ---------------- main sequence ----------------
   int base;

   initial begin
      RST_N = 1'b0;
      REQA_VALID = 1'b0; REQA_OP = 2'd0; REQA_RS1 = 32'd0; REQA_RS2 = 32'd0;
      REQB_VALID = 1'b0; REQB_OP = 2'd0; REQB_RS1 = 32'd0; REQB_RS2 = 32'd0;

      // Contention, both held valid from reset release; reset outputs checked
      // while the requests are already pending.
      rsp_log.delete();
      fork
         begin
            drive_req(1'b0, 2'd0, 32'hFFFF_FFF9, 32'd2);
            drive_req(1'b0, 2'd1, 32'd50, 32'd5);
         end
         drive_req(1'b1, 2'd2, 32'd7, 32'hFFFF_FFFE);
         begin
            #3;
            check_outputs_zero("rst");
            check_eq("rst_state", 64'(DBG_STATE), 64'd0);
            repeat (2) @(posedge CLK);
            #2;
            RST_N = 1'b1;
         end
      join
      wait_rsps(3);
      check_eq("cont_n", 64'(rsp_log.size()), 64'd3);
      check_eq("cont_a1", 64'(rsp_log[0]), 64'({1'b0, 1'b0, 32'hFFFF_FFFD}));
      check_eq("cont_b",  64'(rsp_log[1]), 64'({1'b1, 1'b0, 32'd1}));
      check_eq("cont_a2", 64'(rsp_log[2]), 64'({1'b0, 1'b0, 32'd10}));

      // Single A DIVU 100/7 with the 33-cycle divider.
      rsp_log.delete(); base = rsp_cnt;
      drive_req(1'b0, 2'd1, 32'd100, 32'd7);
      wait_rsps(base + 1);
      check_eq("divu_100_7", 64'(rsp_log[0]), 64'({1'b0, 1'b0, 32'd14}));

      // Signed overflow.
      rsp_log.delete(); base = rsp_cnt;
      drive_req(1'b0, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_rsps(base + 1);
      drive_req(1'b0, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_rsps(base + 2);
      check_eq("ovf_div", 64'(rsp_log[0]), 64'({1'b0, 1'b0, 32'h8000_0000}));
      check_eq("ovf_rem", 64'(rsp_log[1]), 64'({1'b0, 1'b0, 32'd0}));

      // Zero divisor fast path on B.
      rsp_log.delete(); base = rsp_cnt;
      drive_req(1'b1, 2'd0, 32'd5, 32'd0);
      wait_rsps(base + 1);
      drive_req(1'b1, 2'd2, 32'd5, 32'd0);
      wait_rsps(base + 2);
      check_eq("zero_div", 64'(rsp_log[0]), 64'({1'b1, 1'b0, 32'hFFFF_FFFF}));
      check_eq("zero_rem", 64'(rsp_log[1]), 64'({1'b1, 1'b0, 32'd5}));

      // Divider never answers: timeout, then a stray late DIV_READY.
      rsp_log.delete(); base = rsp_cnt;
      div_never = 1'b1;
      drive_req(1'b0, 2'd0, 32'd9, 32'd3);
      wait_rsps(base + 1);
      check_eq("tmo_rsp", 64'(rsp_log[0]), 64'({1'b0, 1'b1, 32'd0}));
      late_rdy = 1'b1;
      @(posedge CLK); #1;
      late_rdy = 1'b0;
      repeat (4) @(posedge CLK); #1;
      check_eq("late_ignored", 64'(rsp_cnt), 64'(base + 1));
      div_never = 1'b0;

      // Result on the last BUSY cycle wins; one cycle later is a timeout.
      rsp_log.delete(); base = rsp_cnt;
      div_lat = TMO;
      drive_req(1'b1, 2'd3, 32'd23, 32'd7);
      wait_rsps(base + 1);
      div_lat = TMO + 1;
      drive_req(1'b1, 2'd3, 32'd23, 32'd7);
      wait_rsps(base + 2);
      check_eq("edge_ok",  64'(rsp_log[0]), 64'({1'b1, 1'b0, 32'd2}));
      check_eq("edge_tmo", 64'(rsp_log[1]), 64'({1'b1, 1'b1, 32'd0}));
      div_lat = 34;

      // Reset 10 cycles after ISSUE.
      drive_req(1'b0, 2'd1, 32'd1000, 32'd10);   // returns in the ISSUE cycle
      repeat (10) @(posedge CLK);
      #2;
      RST_N = 1'b0;
      #1;
      check_outputs_zero("mid_rst");
      exp_q.delete();
      inst_cyc = -1;
      rs_until = 0;
      rr_b     = 1'b0;
      rsp_log.delete(); base = rsp_cnt;
      repeat (2) @(posedge CLK);
      #2;
      RST_N = 1'b1;
      fork
         drive_req(1'b1, 2'd0, 32'd20, 32'd4);
         begin
            #1;
            check_eq("post_rst_ready", 64'({REQA_READY, REQB_READY}), 64'd1);
         end
      join
      wait_rsps(base + 1);
      repeat (40) @(posedge CLK); #1;
      check_eq("post_rst_n", 64'(rsp_cnt), 64'(base + 1));
      check_eq("post_rst_rsp", 64'(rsp_log[0]), 64'({1'b1, 1'b0, 32'd5}));

      // Randomized traffic from both requesters.
      for (int ph = 0; ph < 2; ph++) begin
         div_lat = (ph == 0) ? 34 : $urandom_range(1, 8);
         fork
            rand_requester(1'b0, 15);
            rand_requester(1'b1, 15);
         join
         base = 0;
         while (exp_q.size() != 0 && base < 2000) begin
            @(posedge CLK);
            base++;
         end
         #1;
      end

      check_eq("drain", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
